// File: rtl/imem_load_ctrl_if.sv
// Loader-stream, memory-write and core-control signals of the instruction-memory load controller.
// The controller uses the master modport; the loader/memory/core side uses slave.
interface imem_load_ctrl_if;
    logic        load_req;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        core_stall;
    logic        pc_restart;
    logic        load_done;
    logic        load_err;

    modport master (
        input  load_req, ld_valid, ld_data, ld_last,
        output ld_ready, mem_we, mem_addr, mem_wdata,
        output core_stall, pc_restart, load_done, load_err
    );

    modport slave (
        output load_req, ld_valid, ld_data, ld_last,
        input  ld_ready, mem_we, mem_addr, mem_wdata,
        input  core_stall, pc_restart, load_done, load_err
    );
endinterface

// File: rtl/imem_load_ctrl.sv
// Serialises loader words into little-endian byte writes to the instruction memory,
// stalling the core for the whole load and releasing it with a PC-restart pulse.
module imem_load_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000,
    parameter int unsigned DEPTH_BYTES = 1024
) (
    input logic             clk,
    input logic             rst_n,
    imem_load_ctrl_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH_BYTES) + 1;
    localparam logic [PW-1:0] PtrEnd = PW'(DEPTH_BYTES);

    typedef enum logic [1:0] {StRun, StWaitWord, StWrite, StDone} state_e;

    state_e          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_inc;
    logic [1:0]      byte_cnt_q;
    logic [1:0]      byte_inc;
    logic [31:0]     word_q;
    logic            last_q;
    logic            ld_ready_q;
    logic            mem_we_q;
    logic [31:0]     mem_addr_q;
    logic [7:0]      mem_wdata_q;
    logic            core_stall_q;
    logic            pc_restart_q;
    logic            load_done_q;
    logic            load_err_q;

    always_comb begin
        ptr_inc  = ptr_q + PW'(1);
        byte_inc = byte_cnt_q + 2'd1;
    end

    // Outputs are registered alongside the state so each one is a clean decode of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            ptr_q        <= '0;
            byte_cnt_q   <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
            ld_ready_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            core_stall_q <= 1'b0;
            pc_restart_q <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            pc_restart_q <= 1'b0;
            load_done_q  <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (bus.load_req) begin
                        state_q      <= StWaitWord;
                        ptr_q        <= '0;
                        load_err_q   <= 1'b0;
                        ld_ready_q   <= 1'b1;
                        core_stall_q <= 1'b1;
                    end
                end
                StWaitWord: begin
                    if (bus.ld_valid && ld_ready_q) begin
                        state_q     <= StWrite;
                        word_q      <= bus.ld_data;
                        last_q      <= bus.ld_last;
                        byte_cnt_q  <= '0;
                        ld_ready_q  <= 1'b0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= BASE_ADDR + 32'(ptr_q);
                        mem_wdata_q <= bus.ld_data[7:0];
                    end
                end
                StWrite: begin
                    ptr_q      <= ptr_inc;
                    byte_cnt_q <= byte_inc;
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        if (last_q) begin
                            state_q      <= StDone;
                            load_done_q  <= 1'b1;
                            pc_restart_q <= 1'b1;
                        end else if (ptr_inc == PtrEnd) begin
                            // Memory full without a last word: finish and flag the overflow.
                            state_q      <= StDone;
                            load_err_q   <= 1'b1;
                            load_done_q  <= 1'b1;
                            pc_restart_q <= 1'b1;
                        end else begin
                            state_q    <= StWaitWord;
                            ld_ready_q <= 1'b1;
                        end
                    end else begin
                        mem_addr_q  <= BASE_ADDR + 32'(ptr_inc);
                        mem_wdata_q <= word_q[{byte_inc, 3'b000} +: 8];
                    end
                end
                StDone: begin
                    state_q      <= StRun;
                    core_stall_q <= 1'b0;
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus.ld_ready   = ld_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.core_stall = core_stall_q;
    assign bus.pc_restart = pc_restart_q;
    assign bus.load_done  = load_done_q;
    assign bus.load_err   = load_err_q;
endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: default-depth and 16-byte instances share the loader stimulus;
// byte writes are checked against a scoreboard of expected {address, data} records.
module tb_imem_load_ctrl;
    localparam logic [31:0] BASE = 32'h1000;

    typedef struct {
        logic [31:0] word;
        logic        last;
        int          gap;
        logic [7:0]  b0, b1, b2, b3;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        load_req;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_last;

    logic        m_we, m_ready, m_stall, m_restart, m_done, m_err;
    logic [31:0] m_addr;
    logic [7:0]  m_wdata;

    vec_t        tbl [8];
    wr_t         sb [$];
    wr_t         mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_writes = 0;
    int          n_ready = 0;
    int          n_done = 0;
    int          busy = 0;
    int unsigned exp_ptr = 0;

    always #5 clk = ~clk;

    imem_load_ctrl_if ifa ();
    imem_load_ctrl_if ifb ();

    assign ifa.load_req = load_req & ~sel;
    assign ifa.ld_valid = ld_valid;
    assign ifa.ld_data  = ld_data;
    assign ifa.ld_last  = ld_last;
    assign ifb.load_req = load_req & sel;
    assign ifb.ld_valid = ld_valid;
    assign ifb.ld_data  = ld_data;
    assign ifb.ld_last  = ld_last;

    imem_load_ctrl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.master)
    );

    imem_load_ctrl #(
        .BASE_ADDR   (BASE),
        .DEPTH_BYTES (16)
    ) u_dut_small (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.master)
    );

    always_comb begin
        m_we      = sel ? ifb.mem_we     : ifa.mem_we;
        m_ready   = sel ? ifb.ld_ready   : ifa.ld_ready;
        m_stall   = sel ? ifb.core_stall : ifa.core_stall;
        m_restart = sel ? ifb.pc_restart : ifa.pc_restart;
        m_done    = sel ? ifb.load_done  : ifa.load_done;
        m_err     = sel ? ifb.load_err   : ifa.load_err;
        m_addr    = sel ? ifb.mem_addr   : ifa.mem_addr;
        m_wdata   = sel ? ifb.mem_wdata  : ifa.mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write scoreboard plus per-cycle output invariants of the selected instance.
    always @(negedge clk) begin
        if (m_we) begin
            n_writes++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         m_addr, m_wdata);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", m_addr, mon_e.addr);
                check("wr_data", {24'h0, m_wdata}, {24'h0, mon_e.data});
            end
        end else begin
            check("idle_bus_zero", m_addr | {24'h0, m_wdata}, 32'h0);
        end
        check("stall_decode", {31'h0, m_stall}, {31'h0, m_ready | m_we | m_done});
        check("restart_eq_done", {31'h0, m_restart}, {31'h0, m_done});
        if (m_ready) n_ready++;
        if (m_done) n_done++;
        if (m_stall && !m_done) busy++;
    end

    task automatic start_load();
        @(negedge clk);
        busy     = 0;
        exp_ptr  = 0;
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic send_word(input vec_t v, input logic last, input bit poke, input int budget,
                             output bit acc);
        int t = 0;
        ld_data  = v.word;
        ld_last  = last;
        ld_valid = (v.gap == 0);
        while (!m_ready && t < budget) begin
            @(negedge clk);
            t++;
        end
        acc = m_ready;
        if (!acc) begin
            ld_valid = 1'b0;
            return;
        end
        for (int k = 0; k < v.gap; k++) begin
            load_req = poke && (k == 0);
            @(posedge clk);
            #1;
        end
        load_req = 1'b0;
        ld_valid = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{BASE + exp_ptr,       v.b0});
        sb.push_back('{BASE + exp_ptr + 1,   v.b1});
        sb.push_back('{BASE + exp_ptr + 2,   v.b2});
        sb.push_back('{BASE + exp_ptr + 3,   v.b3});
        exp_ptr += 4;
        if (poke) begin
            load_req = 1'b1;
            @(posedge clk);
            #1;
            load_req = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (m_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_load(input int first, input int n, input int exp_busy, input int exp_rdy);
        int r0;
        int d0;
        bit acc;
        bit seen;
        r0 = n_ready;
        d0 = n_done;
        start_load();
        for (int i = 0; i < n; i++) begin
            send_word(tbl[first + i], tbl[first + i].last, 1'b0, 40, acc);
            check("word_accepted", {31'h0, acc}, 32'h1);
        end
        ld_valid = 1'b0;
        wait_done(80, seen);
        check("done_seen", {31'h0, seen}, 32'h1);
        check("busy_cycles", busy, exp_busy);
        check("ready_cycles", n_ready - r0, exp_rdy);
        check("sb_drained", sb.size(), 0);
        @(negedge clk);
        check("stall_released", {31'h0, m_stall}, 32'h0);
        check("done_pulses", n_done - d0, 1);
        check("no_err", {31'h0, m_err}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  d0;
        int  w0;
        int  r0;
        bit  acc;
        bit  seen;
        vec_t v;

        tbl[0] = '{32'hFFC4A303, 1'b1, 0, 8'h03, 8'hA3, 8'hC4, 8'hFF};
        tbl[1] = '{32'h12345678, 1'b0, 0, 8'h78, 8'h56, 8'h34, 8'h12};
        tbl[2] = '{32'hDEADBEEF, 1'b0, 0, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        tbl[3] = '{32'h00000000, 1'b0, 0, 8'h00, 8'h00, 8'h00, 8'h00};
        tbl[4] = '{32'hA5C30F96, 1'b1, 0, 8'h96, 8'h0F, 8'hC3, 8'hA5};
        tbl[5] = '{32'h0BADF00D, 1'b0, 0, 8'h0D, 8'hF0, 8'hAD, 8'h0B};
        tbl[6] = '{32'h80000001, 1'b0, 3, 8'h01, 8'h00, 8'h00, 8'h80};
        tbl[7] = '{32'h7F7F7F7F, 1'b1, 3, 8'h7F, 8'h7F, 8'h7F, 8'h7F};

        sel      = 1'b0;
        load_req = 1'b0;
        ld_valid = 1'b0;
        ld_data  = '0;
        ld_last  = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", {26'h0, ifa.mem_we, ifa.ld_ready, ifa.core_stall, ifa.pc_restart,
                            ifa.load_done, ifa.load_err}, 32'h0);
        check("rst_addr", ifa.mem_addr, 32'h0);
        check("rst_wdata", {24'h0, ifa.mem_wdata}, 32'h0);
        check("rst_small_err", {31'h0, ifb.load_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single word, back-to-back words, and words with WAIT gaps.
        run_load(0, 1, 5, 1);
        run_load(1, 4, 20, 4);
        run_load(5, 3, 21, 9);

        // Overflow on the 16-byte instance: fifth word must never be accepted.
        sel = 1'b1;
        d0  = n_done;
        w0  = n_writes;
        start_load();
        for (int i = 1; i <= 4; i++) begin
            send_word(tbl[i], 1'b0, 1'b0, 40, acc);
            check("ovf_accept", {31'h0, acc}, 32'h1);
        end
        send_word(tbl[5], 1'b0, 1'b0, 20, acc);
        ld_valid = 1'b0;
        check("ovf_fifth_refused", {31'h0, acc}, 32'h0);
        check("ovf_done", n_done - d0, 1);
        check("ovf_err", {31'h0, m_err}, 32'h1);
        check("ovf_writes", n_writes - w0, 16);
        check("ovf_sb_drained", sb.size(), 0);
        repeat (3) @(negedge clk);
        check("ovf_err_sticky", {31'h0, m_err}, 32'h1);
        d0 = n_done;
        start_load();
        check("err_cleared_by_req", {31'h0, m_err}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            send_word(tbl[i], (i == 4), 1'b0, 40, acc);
            check("fill_accept", {31'h0, acc}, 32'h1);
        end
        ld_valid = 1'b0;
        wait_done(40, seen);
        check("fill_done_seen", {31'h0, seen}, 32'h1);
        check("fill_no_err", {31'h0, m_err}, 32'h0);
        @(negedge clk);
        check("fill_done_pulses", n_done - d0, 1);
        sel = 1'b0;

        // Reset during the second byte of word 2, with load_req held through reset release.
        start_load();
        send_word(tbl[1], 1'b0, 1'b0, 40, acc);
        check("rm_accept1", {31'h0, acc}, 32'h1);
        send_word(tbl[2], 1'b0, 1'b0, 40, acc);
        check("rm_accept2", {31'h0, acc}, 32'h1);
        ld_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rm_flags", {27'h0, m_we, m_ready, m_stall, m_restart, m_done}, 32'h0);
        check("rm_addr", m_addr, 32'h0);
        check("rm_wdata", {24'h0, m_wdata}, 32'h0);
        sb.delete();
        d0 = n_done;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        load_req = 1'b0;
        repeat (3) @(negedge clk);
        check("rm_no_done", n_done - d0, 0);
        check("rm_idle", {30'h0, m_stall, m_ready}, 32'h0);
        run_load(0, 1, 5, 1);

        // load_req pulses during WRITE and WAIT_WORD are ignored.
        d0 = n_done;
        r0 = n_ready;
        start_load();
        send_word(tbl[1], 1'b0, 1'b1, 40, acc);
        check("poke_accept1", {31'h0, acc}, 32'h1);
        v = tbl[6];
        send_word(v, 1'b1, 1'b1, 40, acc);
        check("poke_accept2", {31'h0, acc}, 32'h1);
        ld_valid = 1'b0;
        wait_done(40, seen);
        check("poke_done_seen", {31'h0, seen}, 32'h1);
        check("poke_busy", busy, 13);
        check("poke_ready_cycles", n_ready - r0, 5);
        repeat (4) @(negedge clk);
        check("poke_done_pulses", n_done - d0, 1);
        check("poke_stall_low", {31'h0, m_stall}, 32'h0);
        check("poke_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
